// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with input qualification and a saturating match counter.
// Optional runtime-loadable pattern enabled by defining SEQDET_RUNTIME_PAT_EN.
module seq_detector_param #(
  parameter int unsigned       PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = 4'b1001,
  parameter bit                OVERLAP = 1'b1,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
`ifdef SEQDET_RUNTIME_PAT_EN
  ,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in
`endif
);

  localparam int unsigned HIST_W = PAT_W - 1;
  localparam int unsigned FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                dout_d;
  logic                armed_d;
  logic [PAT_W-1:0]    pat_q;
  logic                load_c;
  logic                match_c;

`ifdef SEQDET_RUNTIME_PAT_EN
  // Runtime pattern register, reset to the elaboration-time pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= PATTERN;
    end else if (pat_load) begin
      pat_q <= pat_in;
    end
  end
  assign load_c = pat_load;
`else
  assign pat_q  = PATTERN;
  assign load_c = 1'b0;
`endif

  // A load discards the bit on the same edge, so it can never match.
  assign match_c = (state_q == ST_ARMED) && din_valid && !load_c &&
                   ({hist_q, din} == pat_q);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    hist_d  = hist_q;
    dout_d  = 1'b0;
    cnt_d   = match_count;

    if (load_c) begin
      state_d = ST_FILL;
      fill_d  = '0;
    end else if (din_valid) begin
      hist_d = HIST_W'({hist_q, din});
      dout_d = match_c;
      if (state_q == ST_FILL) begin
        fill_d = fill_q + FILL_W'(1);
        if (fill_d == FILL_MAX) begin
          state_d = ST_ARMED;
        end
      end else if (match_c && !OVERLAP) begin
        fill_d  = '0;
        state_d = ST_FILL;
      end
    end

    // Clear wins over increment, but a same-edge match still counts once.
    if (cnt_clr) begin
      cnt_d = match_c ? CNT_W'(1) : '0;
    end else if (match_c && (match_count != CNT_MAX)) begin
      cnt_d = match_count + CNT_W'(1);
    end

    armed_d = (state_d == ST_ARMED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FILL;
      fill_q      <= '0;
      hist_q      <= '0;
      dout        <= 1'b0;
      match_count <= '0;
      armed       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      hist_q      <= hist_d;
      dout        <= dout_d;
      match_count <= cnt_d;
      armed       <= armed_d;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: three parameterisations driven from one stream.
// Instance a: defaults; b: non-overlapping; c: PAT_W=3, 111, CNT_W=2.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'd0;

  logic       dout_a, dout_b, dout_c;
  logic       armed_a, armed_b, armed_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_detector_param u_a (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .cnt_clr(cnt_clr),
    .dout(dout_a), .match_count(cnt_a), .armed(armed_a)
`ifdef SEQDET_RUNTIME_PAT_EN
    , .pat_load(pat_load), .pat_in(pat_in)
`endif
  );

  seq_detector_param #(.OVERLAP(1'b0)) u_b (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .cnt_clr(cnt_clr),
    .dout(dout_b), .match_count(cnt_b), .armed(armed_b)
`ifdef SEQDET_RUNTIME_PAT_EN
    , .pat_load(1'b0), .pat_in(4'd0)
`endif
  );

  seq_detector_param #(.PAT_W(3), .PATTERN(3'b111), .OVERLAP(1'b1), .CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .cnt_clr(cnt_clr),
    .dout(dout_c), .match_count(cnt_c), .armed(armed_c)
`ifdef SEQDET_RUNTIME_PAT_EN
    , .pat_load(1'b0), .pat_in(3'd0)
`endif
  );

  typedef struct packed {
    logic [2:0]      dout;
    logic [2:0]      armed;
    logic [2:0][7:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model state, one slot per instance.
  int          m_fill[3];
  logic [31:0] m_hist[3];
  int          m_cnt[3];
  logic [31:0] m_pat[3];
  logic        m_dout[3];

  function automatic int pw(input int k);
    return (k == 2) ? 3 : 4;
  endfunction

  function automatic bit ovl(input int k);
    return k != 1;
  endfunction

  function automatic int cmax(input int k);
    return (k == 2) ? 3 : 255;
  endfunction

  task automatic model_step(input int k, input logic v, input logic d, input logic c,
                            input logic r, input logic ld, input logic [3:0] pin);
    logic [31:0] win;
    logic        hit;
    int          w;
    w   = pw(k);
    hit = 1'b0;
    if (r) begin
      m_fill[k] = 0;
      m_hist[k] = 0;
      m_cnt[k]  = 0;
      m_dout[k] = 1'b0;
      m_pat[k]  = (k == 2) ? 32'd7 : 32'd9;
      return;
    end
    if (ld && k == 0) begin
      m_pat[k]  = {28'd0, pin};
      m_fill[k] = 0;
    end else if (v) begin
      win = ((m_hist[k] << 1) | {31'd0, d}) & ((32'd1 << w) - 32'd1);
      hit = (m_fill[k] == w - 1) && (win == m_pat[k]);
      m_hist[k] = win;
      if (hit && !ovl(k)) m_fill[k] = 0;
      else if (m_fill[k] < w - 1) m_fill[k] = m_fill[k] + 1;
    end
    m_dout[k] = hit;
    if (c) m_cnt[k] = hit ? 1 : 0;
    else if (hit && m_cnt[k] < cmax(k)) m_cnt[k] = m_cnt[k] + 1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic d, input logic c = 1'b0,
                      input logic r = 1'b0, input logic ld = 1'b0, input logic [3:0] pin = 4'd0);
    exp_t e;
    din_valid = v;
    din       = d;
    cnt_clr   = c;
    reset     = r;
    pat_load  = ld;
    pat_in    = pin;
    for (int k = 0; k < 3; k++) begin
      model_step(k, v, d, c, r, ld, pin);
      e.dout[k]  = m_dout[k];
      e.armed[k] = (m_fill[k] == pw(k) - 1);
      e.cnt[k]   = 8'(m_cnt[k]);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("dout_a",  {7'd0, dout_a},  {7'd0, e.dout[0]});
    check("dout_b",  {7'd0, dout_b},  {7'd0, e.dout[1]});
    check("dout_c",  {7'd0, dout_c},  {7'd0, e.dout[2]});
    check("armed_a", {7'd0, armed_a}, {7'd0, e.armed[0]});
    check("armed_b", {7'd0, armed_b}, {7'd0, e.armed[1]});
    check("armed_c", {7'd0, armed_c}, {7'd0, e.armed[2]});
    check("cnt_a",   cnt_a,           e.cnt[0]);
    check("cnt_b",   cnt_b,           e.cnt[1]);
    check("cnt_c",   8'(cnt_c),       e.cnt[2]);
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i]);
  endtask

  initial begin
    logic [15:0] pat_bits;
    #2;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_cnt_a", cnt_a, 8'd0);

    // Overlapping vs non-overlapping on 1001001.
    pat_bits = 16'b1001001;
    feed(pat_bits, 7);
    check("plan1_cnt_a", cnt_a, 8'd2);
    check("plan1_cnt_b", cnt_b, 8'd1);

    // Long invalid gap inside a partial pattern.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("gap_pulse_a", {7'd0, dout_a}, 8'd1);

    // Reset mid-pattern discards history.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_armed_a", {7'd0, armed_a}, 8'd0);
    step(1'b1, 1'b1);
    check("rst_cnt_a", cnt_a, 8'd0);
    check("rst_dout_a", {7'd0, dout_a}, 8'd0);

    // Run of ones: saturation and clear-with-match on the 3-bit instance.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
    check("sat_cnt_c", 8'(cnt_c), 8'd3);
    step(1'b1, 1'b1, 1'b1);
    check("clr_match_cnt_c", 8'(cnt_c), 8'd1);
    step(1'b1, 1'b0, 1'b1);
    check("clr_cnt_c", 8'(cnt_c), 8'd0);

`ifdef SEQDET_RUNTIME_PAT_EN
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110);
    pat_bits = 16'b0110;
    feed(pat_bits, 4);
    check("rt_pulse_a", {7'd0, dout_a}, 8'd1);
    pat_bits = 16'b1001;
    feed(pat_bits, 4);
    check("rt_old_pat_a", cnt_a, 8'd1);
`endif

    // Randomised traffic with gaps, clears and occasional reset.
    for (int i = 0; i < 120; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
